// File: rtl/riscv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_pkg: shared encodings for the multicycle RV32I core control path.
// Rev 1.0
// ---------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [2:0] {
    INSTR_R = 3'd0,
    INSTR_I = 3'd1,
    INSTR_S = 3'd2,
    INSTR_B = 3'd3,
    INSTR_U = 3'd4,
    INSTR_J = 3'd5
  } instr_type_enum;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_enum;

  typedef enum logic [1:0] {
    ALU_CLASS_ADD   = 2'd0,
    ALU_CLASS_SUB   = 2'd1,
    ALU_CLASS_FUNCT = 2'd2
  } alu_class_enum;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_EXEC_I   = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_JAL2     = 4'd11,
    ST_JALR     = 4'd12,
    ST_JALR2    = 4'd13,
    ST_UPPER    = 4'd14,
    ST_TRAP     = 4'd15
  } ctrl_state_enum;

  localparam logic       ADR_PC        = 1'b0;
  localparam logic       ADR_ALUOUT    = 1'b1;
  localparam logic [1:0] RES_ALUOUT    = 2'd0;
  localparam logic [1:0] RES_DATA      = 2'd1;
  localparam logic [1:0] RES_ALURESULT = 2'd2;
  localparam logic [1:0] SRC_A_PC      = 2'd0;
  localparam logic [1:0] SRC_A_OLDPC   = 2'd1;
  localparam logic [1:0] SRC_A_RS1     = 2'd2;
  localparam logic [1:0] SRC_A_ZERO    = 2'd3;
  localparam logic [1:0] SRC_B_RS2     = 2'd0;
  localparam logic [1:0] SRC_B_IMM     = 2'd1;
  localparam logic [1:0] SRC_B_FOUR    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_decoder: maps the FSM's ALU class and funct fields to an ALU operation.
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_decoder
  import riscv_pkg::*;
(
  input  logic          funct7b5,
  input  logic [2:0]    funct3,
  input  logic          is_op_imm,
  input  alu_class_enum alu_op_class,
  output alu_op_enum    alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op_class)
      ALU_CLASS_SUB: alu_control = ALU_SUB;
      ALU_CLASS_FUNCT: begin
        case (funct3)
          // bit 30 is part of the immediate for ADDI, so only OP may subtract
          3'b000:  alu_control = (funct7b5 && !is_op_imm) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_controller: main control FSM sequencing the shared RV32I datapath.
// Rev 1.0
// ---------------------------------------------------------------------------
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter bit RESET_PC_WRITE = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [6:0]     op,
  input  logic [2:0]     funct3,
  input  logic           funct7b5,
  input  logic           zero,
  input  logic           lt,
  input  logic           ltu,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_write,
  output logic           adr_src,
  output logic           ir_write,
  output logic           pc_write,
  output logic           reg_write,
  output logic [1:0]     result_src,
  output logic [1:0]     alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [3:0]     alu_control,
  output instr_type_enum instr_type,
  output logic           illegal_instr
);

  ctrl_state_enum state_q, state_d;
  logic           illegal_q, illegal_d;
  logic           boot_q;
  alu_class_enum  alu_class;
  logic           is_op_imm;
  logic           taken;
  alu_op_enum     alu_op;

  alu_decoder u_alu_decoder (
    .funct7b5     (funct7b5),
    .funct3       (funct3),
    .is_op_imm    (is_op_imm),
    .alu_op_class (alu_class),
    .alu_control  (alu_op)
  );

  assign alu_control   = alu_op;
  assign illegal_instr = illegal_q;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = ADR_PC;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_class  = ALU_CLASS_ADD;
    is_op_imm  = 1'b0;
    instr_type = INSTR_R;

    case (state_q)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_IMM;
        instr_type = INSTR_B;
        case (op)
          OP_LOAD, OP_STORE: state_d = ST_MEMADR;
          OP_OP:             state_d = ST_EXEC_R;
          OP_OPIMM:          state_d = ST_EXEC_I;
          OP_BRANCH:         state_d = ST_BRANCH;
          OP_JAL:            state_d = ST_JAL;
          OP_JALR:           state_d = ST_JALR;
          OP_LUI, OP_AUIPC:  state_d = ST_UPPER;
          default: begin
            state_d   = ST_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_MEMADR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        instr_type = (op == OP_STORE) ? INSTR_S : INSTR_I;
        state_d    = (op == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
      end
      ST_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = ADR_ALUOUT;
        if (mem_ready) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = ADR_ALUOUT;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_class = ALU_CLASS_FUNCT;
        state_d   = ST_ALUWB;
      end
      ST_EXEC_I: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        instr_type = INSTR_I;
        alu_class  = ALU_CLASS_FUNCT;
        is_op_imm  = 1'b1;
        state_d    = ST_ALUWB;
      end
      ST_ALUWB: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_class = ALU_CLASS_SUB;
        pc_write  = taken;
        if (funct3 == 3'b010 || funct3 == 3'b011) illegal_d = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_JAL, ST_JALR: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALURESULT;
        reg_write  = 1'b1;
        state_d    = (state_q == ST_JAL) ? ST_JAL2 : ST_JALR2;
      end
      ST_JAL2: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_IMM;
        instr_type = INSTR_J;
        result_src = RES_ALURESULT;
        pc_write   = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_JALR2: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        instr_type = INSTR_I;
        result_src = RES_ALURESULT;
        pc_write   = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_UPPER: begin
        instr_type = INSTR_U;
        alu_src_a  = (op == OP_LUI) ? SRC_A_ZERO : SRC_A_OLDPC;
        alu_src_b  = SRC_B_IMM;
        result_src = RES_ALURESULT;
        reg_write  = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_TRAP: illegal_d = 1'b1;
      default: state_d = ST_FETCH;
    endcase

    if (RESET_PC_WRITE && boot_q) pc_write = 1'b1;

    // Reset abandons whatever is in flight: no strobe may leave this cycle
    if (reset) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      boot_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      boot_q    <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multicycle_controller: directed instruction sequences with a scoreboard.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_multicycle_controller;
  import riscv_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic [6:0]     op;
  logic [2:0]     funct3;
  logic           funct7b5;
  logic           zero, lt, ltu, mem_ready;
  logic           mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]     result_src, alu_src_a, alu_src_b;
  logic [3:0]     alu_control;
  instr_type_enum instr_type;
  logic           illegal_instr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [20:0] exp_q[$];
  string       name_q[$];

  multicycle_controller #(.RESET_PC_WRITE(1'b0)) dut (
    .clk           (clk),
    .reset         (reset),
    .op            (op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .lt            (lt),
    .ltu           (ltu),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_control   (alu_control),
    .instr_type    (instr_type),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
  //  result_src, alu_src_a, alu_src_b, alu_control, instr_type, illegal}
  function automatic logic [20:0] v(input int mreq, mwr, adr, irw, pcw, rgw,
                                    input int rs, sa, sb, alu, it, ill);
    return {mreq[0], mwr[0], adr[0], irw[0], pcw[0], rgw[0],
            rs[1:0], sa[1:0], sb[1:0], alu[3:0], it[2:0], ill[0]};
  endfunction

  // Monitor: outputs are presented every cycle; compare at the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [20:0] act, exp_v;
      string       nm;
      act   = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_control, 3'(instr_type),
               illegal_instr};
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      n_checks++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", nm, act, exp_v);
      end
    end
  end

  task automatic cyc(input logic [20:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] i);
    op       = i[6:0];
    funct3   = i[14:12];
    funct7b5 = i[30];
  endtask

  task automatic fetch_decode(input string nm, input int ill);
    mem_ready = 1'b1;
    cyc(v(1,0,0,1,1,0, 0,0,2,0,0,ill), {nm, "_fetch"});
    cyc(v(0,0,0,0,0,0, 0,1,1,0,3,ill), {nm, "_decode"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    set_instr(32'h0000_0013);
    @(posedge clk); #1;
    cyc(v(0,0,0,0,0,0, 0,0,2,0,0,0), "reset_fetch");
    reset = 1'b0;

    // R-type: add, sub, sra
    set_instr(32'h0020_81B3);
    fetch_decode("add", 0);
    cyc(v(0,0,0,0,0,0, 0,2,0,0,0,0), "add_exec");
    cyc(v(0,0,0,0,0,1, 0,0,0,0,0,0), "add_wb");
    set_instr(32'h4020_81B3);
    fetch_decode("sub", 0);
    cyc(v(0,0,0,0,0,0, 0,2,0,1,0,0), "sub_exec");
    cyc(v(0,0,0,0,0,1, 0,0,0,0,0,0), "sub_wb");
    set_instr(32'h4020_D1B3);
    fetch_decode("sra", 0);
    cyc(v(0,0,0,0,0,0, 0,2,0,7,0,0), "sra_exec");
    cyc(v(0,0,0,0,0,1, 0,0,0,0,0,0), "sra_wb");

    // lw with two wait cycles; mem_ready high in MEMADR must be ignored
    set_instr(32'h0000_A183);
    fetch_decode("lw", 0);
    cyc(v(0,0,0,0,0,0, 0,2,1,0,1,0), "lw_memadr");
    mem_ready = 1'b0;
    cyc(v(1,0,1,0,0,0, 0,0,0,0,0,0), "lw_wait1");
    cyc(v(1,0,1,0,0,0, 0,0,0,0,0,0), "lw_wait2");
    mem_ready = 1'b1;
    cyc(v(1,0,1,0,0,0, 0,0,0,0,0,0), "lw_read");
    cyc(v(0,0,0,0,0,1, 1,0,0,0,0,0), "lw_wb");

    // sw, then a stalled fetch showing no second strobe
    set_instr(32'h0020_A023);
    fetch_decode("sw", 0);
    cyc(v(0,0,0,0,0,0, 0,2,1,0,2,0), "sw_memadr");
    cyc(v(1,1,1,0,0,0, 0,0,0,0,0,0), "sw_write");
    mem_ready = 1'b0;
    cyc(v(1,0,0,0,0,0, 0,0,2,0,0,0), "sw_next_fetch_wait");

    // branches
    set_instr(32'h0020_8463); zero = 1'b1;
    fetch_decode("beq_t", 0);
    cyc(v(0,0,0,0,1,0, 0,2,0,1,0,0), "beq_taken");
    zero = 1'b0;
    fetch_decode("beq_nt", 0);
    cyc(v(0,0,0,0,0,0, 0,2,0,1,0,0), "beq_not_taken");
    set_instr(32'h0020_9463);
    fetch_decode("bne", 0);
    cyc(v(0,0,0,0,1,0, 0,2,0,1,0,0), "bne_taken");
    set_instr(32'h0020_C463); lt = 1'b0;
    fetch_decode("blt", 0);
    cyc(v(0,0,0,0,0,0, 0,2,0,1,0,0), "blt_not_taken");
    set_instr(32'h0020_F463); ltu = 1'b1;
    fetch_decode("bgeu", 0);
    cyc(v(0,0,0,0,0,0, 0,2,0,1,0,0), "bgeu_not_taken");
    ltu = 1'b0;

    // sw interrupted by reset while waiting in MEMWRITE
    set_instr(32'h0020_A023);
    fetch_decode("sw_rst", 0);
    cyc(v(0,0,0,0,0,0, 0,2,1,0,2,0), "sw_rst_memadr");
    mem_ready = 1'b0;
    cyc(v(1,1,1,0,0,0, 0,0,0,0,0,0), "sw_rst_wait");
    reset = 1'b1;
    cyc(v(0,0,1,0,0,0, 0,0,0,0,0,0), "sw_rst_reset_cycle");
    reset = 1'b0;
    cyc(v(1,0,0,0,0,0, 0,0,2,0,0,0), "sw_rst_refetch");

    // jal, lui, auipc
    set_instr(32'h0080_00EF);
    fetch_decode("jal", 0);
    cyc(v(0,0,0,0,0,1, 2,1,2,0,0,0), "jal_link");
    cyc(v(0,0,0,0,1,0, 2,1,1,0,5,0), "jal2_target");
    set_instr(32'h0000_10B7);
    fetch_decode("lui", 0);
    cyc(v(0,0,0,0,0,1, 2,3,1,0,4,0), "lui_upper");
    set_instr(32'h0000_1097);
    fetch_decode("auipc", 0);
    cyc(v(0,0,0,0,0,1, 2,1,1,0,4,0), "auipc_upper");

    // unknown opcode traps; sticky until reset, which refetches
    set_instr(32'h0000_007F);
    fetch_decode("trap", 0);
    cyc(v(0,0,0,0,0,0, 0,0,0,0,0,1), "trap_1");
    cyc(v(0,0,0,0,0,0, 0,0,0,0,0,1), "trap_2");
    reset = 1'b1;
    cyc(v(0,0,0,0,0,0, 0,0,0,0,0,1), "trap_reset_cycle");
    reset = 1'b0;
    set_instr(32'h0020_A463);
    fetch_decode("bad_branch", 0);
    cyc(v(0,0,0,0,0,0, 0,2,0,1,0,0), "bad_branch_exec");
    mem_ready = 1'b0;
    cyc(v(1,0,0,0,0,0, 0,0,2,0,0,1), "bad_branch_sticky");

    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
